spi_master: RTL and testbench

SPI mode-0 master that serialises one DATA_W-bit word from the AES core onto MOSI and captures a word returned by the SPI slave on MISO, MSB first, full duplex. It sits directly upstream of the SPI slave and drives its sclk, CS and mosi inputs from the system clock. A start/busy/done handshake faces the host side; CS is active-low and spans each frame.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_div.sv | 27 ++
 rtl/spi_master.sv | 125 ++++++++++++
 tb/tb_spi_master.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, chip-select active level and
// default frame geometry. Used by spi_master and by the SPI slave bench.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  localparam logic CS_ACTIVE   = 1'b0;
  localparam int   SPI_DATA_W  = 8;
  localparam int   SPI_CLK_DIV = 4;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for the SPI master.
//   clk   : system clock
//   reset : async active-low reset
//   clr   : restart the count (FSM changes state this cycle)
//   tick  : high in the CLK_DIV-th cycle since the last clear/tick
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV) + 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, full duplex, one DATA_W-bit word per frame.
//   clk/reset        : system clock, async active-low reset
//   start, MDS       : frame request and word to send (sampled in IDLE)
//   MDO, done        : received word, one-cycle completion pulse
//   busy             : frame in progress (SETUP..GAP)
//   sclk, CS, mosi   : serial clock (idles low), active-low select, data out
//   MISO             : serial data in
// Optional build macro SPI_MASTER_BURST_EN: start in the last HOLD cycle
// chains the next frame directly into SETUP with CS kept low.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] MDS,
  output logic [DATA_W-1:0] MDO,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              CS,
  output logic              mosi,
  input  logic              MISO
);

  localparam int BW = $clog2(DATA_W) + 1;

  spi_state_e        state, nstate;
  logic [DATA_W-1:0] tx, rx;
  logic [BW-1:0]     nfall;   // falling sclk edges issued this frame
  logic              tick, clr, xfer_end, burst_go;

`ifdef SPI_MASTER_BURST_EN
  assign burst_go = start;
`else
  assign burst_go = 1'b0;
`endif

  // All DATA_W falls done; the trailing low half-period closes XFER.
  assign xfer_end = (nfall == BW'(DATA_W));
  assign clr      = (nstate != state);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (start) nstate = SETUP;
      SETUP: if (tick) nstate = XFER;
      XFER:  if (tick && !sclk && xfer_end) nstate = HOLD;
      HOLD:  if (tick) nstate = burst_go ? SETUP : GAP;
      GAP:   if (tick) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    CS   = ~CS_ACTIVE;
    mosi = 1'b0;
    if (state == SETUP || state == XFER || state == HOLD) begin
      CS   = CS_ACTIVE;
      mosi = tx[DATA_W-1];
    end
  end

  // Datapath. The SETUP->XFER tick is the first rising edge, so MISO is
  // sampled there too; no tx shift on the final fall so mosi holds the LSB
  // through HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx    <= '0;
      rx    <= '0;
      nfall <= '0;
      sclk  <= 1'b0;
      done  <= 1'b0;
      MDO   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          tx    <= MDS;
          nfall <= '0;
        end
        SETUP: if (tick) begin
          sclk <= 1'b1;
          rx   <= {rx[DATA_W-2:0], MISO};
        end
        XFER: if (tick) begin
          if (sclk) begin
            sclk  <= 1'b0;
            nfall <= nfall + BW'(1);
            if (nfall < BW'(DATA_W - 1)) tx <= {tx[DATA_W-2:0], 1'b0};
          end else if (!xfer_end) begin
            sclk <= 1'b1;
            rx   <= {rx[DATA_W-2:0], MISO};
          end
        end
        HOLD: if (tick) begin
          done <= 1'b1;
          MDO  <= rx;
          if (burst_go) begin
            tx    <= MDS;
            nfall <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master (DATA_W=8, CLK_DIV=4). A cycle-index
// model derives every output from the frame timeline; a mode-0 slave model
// (or a mosi->MISO loopback) supplies MISO.
module tb_spi_master;

  localparam int W     = 8;
  localparam int T     = 4;
  localparam int TDONE = (2*W+2)*T + 1;  // 73: done / first GAP cycle
  localparam int TEND  = (2*W+3)*T;      // 76: last busy cycle
`ifdef SPI_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [W-1:0] mds = '0, mdo;
  logic         busy, done, sclk, cs, mosi, miso_w;
  int           tests = 0, fails = 0;

  always #5 clk = ~clk;

  spi_master #(.DATA_W(W), .CLK_DIV(T)) dut (
    .clk(clk), .reset(reset), .start(start), .MDS(mds), .MDO(mdo),
    .busy(busy), .done(done), .sclk(sclk), .CS(cs), .mosi(mosi), .MISO(miso_w)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- slave model (mode 0) ----------------
  bit           loop = 1'b1;
  logic [W-1:0] sword = '0;
  int           sidx = 0;
  logic         ps = 1'b0, sbit = 1'b0;
  assign miso_w = loop ? mosi : sbit;

  initial forever begin
    @(posedge clk); #1;
    if (cs)               sidx = 0;
    else if (ps && !sclk) sidx++;
    ps   = sclk;
    sbit = (sidx < W) ? sword[W-1-sidx] : 1'b0;
  end

  // ---------------- timeline model ----------------
  int           t = 0;      // cycles since acceptance, 0 = idle
  logic [W-1:0] mdata = '0, mrx = '0, mdo_e = '0;
  bit           done_e = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t = 0; done_e = 0; mdo_e = '0;
    end else begin
      done_e = 0;
      if (t == 0) begin
        if (start) begin t = 1; mdata = mds; mrx = loop ? mds : sword; end
      end else if (BURST && t == (2*W+2)*T && start) begin
        done_e = 1; mdo_e = mrx; t = 1; mdata = mds; mrx = loop ? mds : sword;
      end else begin
        t++;
        if (t == TDONE) begin done_e = 1; mdo_e = mrx; end
        if (t > TEND) t = 0;
      end
    end
  end

  function automatic logic cs_e(input int tt);
    return !(tt >= 1 && tt <= (2*W+2)*T);
  endfunction

  function automatic logic sclk_e(input int tt);
    if (tt < T+1 || tt > (2*W+1)*T) return 1'b0;
    return (((tt-T-1)/T) % 2) == 0;
  endfunction

  // Bit k is on mosi from half-period 2k-1 (after the k-th fall) onward.
  function automatic logic mosi_e(input int tt, input logic [W-1:0] d);
    int k;
    if (tt < 1 || tt > (2*W+2)*T) return 1'b0;
    if (tt <= T) k = 0;
    else begin
      k = (((tt-T-1)/T) + 1) / 2;
      if (k > W-1) k = W-1;
    end
    return d[W-1-k];
  endfunction

  bit cmp_en = 1'b0;
  always @(negedge clk) if (cmp_en) begin
    chk("m_cs",   cs,   cs_e(t));
    chk("m_sclk", sclk, sclk_e(t));
    chk("m_mosi", mosi, mosi_e(t, mdata));
    chk("m_busy", busy, t != 0);
    chk("m_done", done, done_e);
    chk("m_mdo",  mdo,  mdo_e);
  end

  // ---------------- directed frame ----------------
  task automatic frame(input logic [W-1:0] d, input bit lb, input logic [W-1:0] sw,
                       input bit poke, output int dcyc, output int icyc,
                       output logic [W-1:0] mb, output int rises, output int nd,
                       output int chigh);
    int   cyc;
    logic prv;
    dcyc = -1; icyc = -1; mb = '0; rises = 0; nd = 0; chigh = 0; prv = 1'b0;
    @(posedge clk); #1; mds = d; loop = lb; sword = sw; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; mds = ~d; cyc = 1;
    while (cyc < 200) begin
      @(negedge clk);
      if (cyc == 1) chk("cs_low_c1", cs, 1'b0);
      if (sclk && !prv) begin rises++; mb = {mb[W-2:0], mosi}; end
      prv = sclk;
      if (done) begin nd++; if (dcyc < 0) dcyc = cyc; end
      if (cs && busy) chigh++;
      if (!busy) begin icyc = cyc; break; end
      @(posedge clk); #1; cyc++;
      start = poke && (cyc == 20 || cyc == 70);
    end
    if (icyc < 0) begin
      tests++; fails++;
      $display("FAIL frame_timeout: busy still high after %0d cycles", cyc);
    end
  endtask

  int           dc, ic, rs, nd, ch;
  logic [W-1:0] mb;

  initial begin
    cmp_en = 1'b1;
    reset = 1'b0; start = 1'b1; mds = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", sclk, 0); chk("rst_cs", cs, 1); chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_mdo", mdo, 8'h00);
    start = 1'b0; reset = 1'b1;

    frame(8'hA5, 1'b1, 8'h00, 1'b0, dc, ic, mb, rs, nd, ch);
    chk("a5_done_cyc", dc, 73); chk("a5_idle_cyc", ic, 77);
    chk("a5_rises", rs, 8);     chk("a5_mosi", mb, 8'hA5);
    chk("a5_mdo", mdo, 8'hA5);  chk("a5_ndone", nd, 1);

    frame(8'h3C, 1'b0, 8'hC3, 1'b0, dc, ic, mb, rs, nd, ch);
    chk("fd_mosi", mb, 8'h3C); chk("fd_mdo", mdo, 8'hC3); chk("fd_done_cyc", dc, 73);

    if (!BURST) begin
      frame(8'h5A, 1'b1, 8'h00, 1'b1, dc, ic, mb, rs, nd, ch);
      chk("ign_ndone", nd, 1); chk("ign_gap_cs", ch >= T, 1);
      chk("ign_mdo", mdo, 8'h5A); chk("ign_idle_cyc", ic, 77);
    end

    // Reset in cycle 30 of a frame.
    @(posedge clk); #1; mds = 8'hF0; loop = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (29) @(posedge clk);
    #2; reset = 1'b0; #1;
    chk("ab_cs", cs, 1); chk("ab_sclk", sclk, 0); chk("ab_busy", busy, 0);
    nd = 0;
    repeat (6) begin @(negedge clk); if (done) nd++; end
    chk("ab_nodone", nd, 0);
    @(posedge clk); #1; reset = 1'b1;
    frame(8'h0F, 1'b1, 8'h00, 1'b0, dc, ic, mb, rs, nd, ch);
    chk("ab_mdo", mdo, 8'h0F); chk("ab_done_cyc", dc, 73);

    if (BURST) begin : burst_t
      int cyc, d1, d2, cshi;
      d1 = -1; d2 = -1; cshi = 0;
      @(posedge clk); #1; loop = 1'b1; mds = 8'h11; start = 1'b1;
      @(posedge clk); #1; mds = 8'h22; cyc = 1;
      while (cyc < 200 && d2 < 0) begin
        @(negedge clk);
        if (done) begin
          if (d1 < 0) begin d1 = cyc; chk("b_mdo1", mdo, 8'h11); end
          else begin d2 = cyc; chk("b_mdo2", mdo, 8'h22); end
        end
        if (d1 < 0 && cs) cshi++;
        @(posedge clk); #1; cyc++;
        if (d1 >= 0) start = 1'b0;
      end
      chk("b_cs_low", cshi, 0);
      chk("b_spacing", d2 - d1, (2*W+2)*T);
      repeat (12) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
